// File: rtl/baser_xgmii_dec_64_if.sv
// Receive-side bus bundle for the 64b/66b block decoder.
// The master drives encoded blocks in; the slave (decoder) returns decoded XGMII lanes and status flags.
interface baser_xgmii_dec_64_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned HDR_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0]   encoded_rx_data;
    logic [HDR_WIDTH-1:0]    encoded_rx_hdr;
    logic                    encoded_rx_valid;
    logic [DATA_WIDTH-1:0]   xgmii_rxd;
    logic [DATA_WIDTH/8-1:0] xgmii_rxc;
    logic                    rx_bad_block;
    logic                    rx_sequence_error;
    logic                    rx_idle_fill;
    logic [CNT_WIDTH-1:0]    rx_error_count;

    modport master (
        output encoded_rx_data, encoded_rx_hdr, encoded_rx_valid,
        input  xgmii_rxd, xgmii_rxc, rx_bad_block, rx_sequence_error,
               rx_idle_fill, rx_error_count
    );

    modport slave (
        input  encoded_rx_data, encoded_rx_hdr, encoded_rx_valid,
        output xgmii_rxd, xgmii_rxc, rx_bad_block, rx_sequence_error,
               rx_idle_fill, rx_error_count
    );
endinterface

// File: rtl/baser_xgmii_dec_64.sv
// 10GBASE-R 64b/66b receive decoder to 64-bit XGMII.
// Decodes sync header/block type into lanes, regenerates dropped idles, checks frame sequencing
// and keeps a saturating error count. All outputs are registered (1-cycle latency).
module baser_xgmii_dec_64 #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned HDR_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic                clk,
    input logic                rst,
    baser_xgmii_dec_64_if.slave rx
);
    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("baser_xgmii_dec_64: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("baser_xgmii_dec_64: HDR_WIDTH must be 2");
    end
    if (CTRL_WIDTH != DATA_WIDTH / 8) begin : g_bad_ctrl_width
        $error("baser_xgmii_dec_64: CTRL_WIDTH must be DATA_WIDTH/8");
    end

    localparam logic [DATA_WIDTH-1:0] ERR_BLK  = {CTRL_WIDTH{8'hfe}};
    localparam logic [DATA_WIDTH-1:0] IDLE_BLK = {CTRL_WIDTH{8'h07}};

    typedef enum logic {S_IDLE, S_FRAME} state_t;
    typedef enum logic [1:0] {K_DATA, K_CTRL, K_START, K_TERM} kind_t;

    state_t                state_q, state_d;
    kind_t                 dec_kind;
    logic [DATA_WIDTH-1:0] dec_rxd, pay_sh;
    logic [CTRL_WIDTH-1:0] dec_rxc, cbad;
    logic                  dec_bad, is_term, obad, seq_err;
    logic [7:0]            cbyte [CTRL_WIDTH];
    logic [8:0]            o0, o4;
    int unsigned           term_lane;

    logic [DATA_WIDTH-1:0] rxd_q, rxd_d;
    logic [CTRL_WIDTH-1:0] rxc_q, rxc_d;
    logic                  bad_q, bad_d, seq_q, seq_d, fill_q, fill_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // {bad, xgmii byte} for a 7-bit control code
    function automatic logic [8:0] ctrl_dec(input logic [6:0] c);
        case (c)
            7'h00:   return {1'b0, 8'h07};
            7'h06:   return {1'b0, 8'h06};
            7'h1e:   return {1'b0, 8'hfe};
            7'h2d:   return {1'b0, 8'h1c};
            7'h33:   return {1'b0, 8'h3c};
            7'h4b:   return {1'b0, 8'h7c};
            7'h55:   return {1'b0, 8'hbc};
            7'h66:   return {1'b0, 8'hdc};
            7'h78:   return {1'b0, 8'hf7};
            default: return {1'b1, 8'hfe};
        endcase
    endfunction

    // {bad, xgmii byte} for a 4-bit ordered-set code
    function automatic logic [8:0] o_dec(input logic [3:0] o);
        case (o)
            4'h0:    return {1'b0, 8'h9c};
            4'hf:    return {1'b0, 8'h5c};
            default: return {1'b1, 8'hfe};
        endcase
    endfunction

    // Block decode: lane contents, legality and block class, independent of frame state
    always_comb begin
        dec_rxd   = ERR_BLK;
        dec_rxc   = '1;
        dec_bad   = 1'b0;
        dec_kind  = K_CTRL;
        is_term   = 1'b0;
        obad      = 1'b0;
        term_lane = 0;
        pay_sh    = rx.encoded_rx_data >> 8;
        for (int unsigned i = 0; i < CTRL_WIDTH; i++) begin
            {cbad[i], cbyte[i]} = ctrl_dec(rx.encoded_rx_data[8 + 7 * i +: 7]);
        end
        o0 = o_dec(rx.encoded_rx_data[35:32]);
        o4 = o_dec(rx.encoded_rx_data[39:36]);

        if (rx.encoded_rx_hdr == 2'b10) begin
            dec_rxd  = rx.encoded_rx_data;
            dec_rxc  = '0;
            dec_kind = K_DATA;
        end else if (rx.encoded_rx_hdr == 2'b01) begin
            case (rx.encoded_rx_data[7:0])
                8'h1e: begin
                    for (int unsigned i = 0; i < CTRL_WIDTH; i++) dec_rxd[8 * i +: 8] = cbyte[i];
                    dec_bad = |cbad;
                end
                8'h2d: begin
                    for (int unsigned i = 0; i < 4; i++) dec_rxd[8 * i +: 8] = cbyte[i];
                    dec_rxd[39:32] = o4[7:0];
                    dec_rxd[63:40] = rx.encoded_rx_data[63:40];
                    dec_rxc        = 8'h1f;
                    dec_bad        = |cbad[3:0];
                    obad           = o4[8];
                end
                8'h33: begin
                    for (int unsigned i = 0; i < 4; i++) dec_rxd[8 * i +: 8] = cbyte[i];
                    dec_rxd[39:32] = 8'hfb;
                    dec_rxd[63:40] = rx.encoded_rx_data[63:40];
                    dec_rxc        = 8'h1f;
                    dec_bad        = |cbad[3:0];
                    dec_kind       = K_START;
                end
                8'h66: begin
                    dec_rxd  = {rx.encoded_rx_data[63:40], 8'hfb, rx.encoded_rx_data[31:8], o0[7:0]};
                    dec_rxc  = 8'h11;
                    obad     = o0[8];
                    dec_kind = K_START;
                end
                8'h55: begin
                    dec_rxd = {rx.encoded_rx_data[63:40], o4[7:0], rx.encoded_rx_data[31:8], o0[7:0]};
                    dec_rxc = 8'h11;
                    obad    = o0[8] | o4[8];
                end
                8'h78: begin
                    dec_rxd  = {rx.encoded_rx_data[63:8], 8'hfb};
                    dec_rxc  = 8'h01;
                    dec_kind = K_START;
                end
                8'h4b: begin
                    dec_rxd[31:0] = {rx.encoded_rx_data[31:8], o0[7:0]};
                    for (int unsigned i = 4; i < CTRL_WIDTH; i++) dec_rxd[8 * i +: 8] = cbyte[i];
                    dec_rxc = 8'hf1;
                    dec_bad = |cbad[7:4];
                    obad    = o0[8];
                end
                8'h87: begin is_term = 1'b1; term_lane = 0; end
                8'h99: begin is_term = 1'b1; term_lane = 1; end
                8'haa: begin is_term = 1'b1; term_lane = 2; end
                8'hb4: begin is_term = 1'b1; term_lane = 3; end
                8'hcc: begin is_term = 1'b1; term_lane = 4; end
                8'hd2: begin is_term = 1'b1; term_lane = 5; end
                8'he1: begin is_term = 1'b1; term_lane = 6; end
                8'hff: begin is_term = 1'b1; term_lane = 7; end
                default: dec_bad = 1'b1;
            endcase
            // Terminate: data bytes sit one byte up in the payload; control codes keep their 7-bit slots
            if (is_term) begin
                dec_kind = K_TERM;
                dec_rxc  = 8'hff << term_lane;
                for (int unsigned i = 0; i < CTRL_WIDTH; i++) begin
                    if (i < term_lane) begin
                        dec_rxd[8 * i +: 8] = pay_sh[8 * i +: 8];
                    end else if (i == term_lane) begin
                        dec_rxd[8 * i +: 8] = 8'hfd;
                    end else begin
                        dec_rxd[8 * i +: 8] = cbyte[i];
                        dec_bad = dec_bad | cbad[i];
                    end
                end
            end
            if (obad) begin
                dec_rxd = ERR_BLK;
                dec_rxc = '1;
                dec_bad = 1'b1;
            end
        end else begin
            dec_bad = 1'b1;
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next frame state and sequence legality
    always_comb begin
        state_d = state_q;
        seq_err = 1'b0;
        if (!rx.encoded_rx_valid) begin
            seq_err = (state_q == S_FRAME);
            state_d = S_IDLE;
        end else if (dec_bad) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dec_kind == K_START) state_d = S_FRAME;
                    else if (dec_kind == K_DATA || dec_kind == K_TERM) seq_err = 1'b1;
                end
                S_FRAME: begin
                    case (dec_kind)
                        K_DATA:  state_d = S_FRAME;
                        K_TERM:  state_d = S_IDLE;
                        K_START: seq_err = 1'b1;
                        default: begin seq_err = 1'b1; state_d = S_IDLE; end
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output selection: idle fill, decoded block or error block, plus saturating error count
    always_comb begin
        rxd_d  = dec_rxd;
        rxc_d  = dec_rxc;
        bad_d  = 1'b0;
        seq_d  = 1'b0;
        fill_d = 1'b0;
        if (!rx.encoded_rx_valid) begin
            if (state_q == S_FRAME) begin
                rxd_d = ERR_BLK;
                rxc_d = '1;
                seq_d = 1'b1;
            end else begin
                rxd_d  = IDLE_BLK;
                rxc_d  = '1;
                fill_d = 1'b1;
            end
        end else if (dec_bad) begin
            bad_d = 1'b1;
        end else if (seq_err) begin
            rxd_d = ERR_BLK;
            rxc_d = '1;
            seq_d = 1'b1;
        end
        cnt_d = cnt_q;
        if ((bad_d || seq_d) && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_q  <= IDLE_BLK;
            rxc_q  <= '1;
            bad_q  <= 1'b0;
            seq_q  <= 1'b0;
            fill_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            rxd_q  <= rxd_d;
            rxc_q  <= rxc_d;
            bad_q  <= bad_d;
            seq_q  <= seq_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rx.xgmii_rxd         = rxd_q;
    assign rx.xgmii_rxc         = rxc_q;
    assign rx.rx_bad_block      = bad_q;
    assign rx.rx_sequence_error = seq_q;
    assign rx.rx_idle_fill      = fill_q;
    assign rx.rx_error_count    = cnt_q;
endmodule

// File: tb/tb_baser_xgmii_dec_64.sv
// Directed bench for baser_xgmii_dec_64: stimulus pushes hand-computed expectations into a
// scoreboard queue, a monitor pops one entry per clock and compares. A second DUT with a
// 2-bit error counter sees the same blocks to exercise saturation.
module tb_baser_xgmii_dec_64;
    localparam logic [63:0] EB  = 64'hfefefefefefefefe;
    localparam logic [63:0] IDL = 64'h0707070707070707;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    baser_xgmii_dec_64_if #(.DATA_WIDTH(64), .HDR_WIDTH(2), .CNT_WIDTH(16)) bus1 ();
    baser_xgmii_dec_64_if #(.DATA_WIDTH(64), .HDR_WIDTH(2), .CNT_WIDTH(2))  bus2 ();

    assign bus2.encoded_rx_data  = bus1.encoded_rx_data;
    assign bus2.encoded_rx_hdr   = bus1.encoded_rx_hdr;
    assign bus2.encoded_rx_valid = bus1.encoded_rx_valid;

    baser_xgmii_dec_64 #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .HDR_WIDTH(2), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus1.slave)
    );

    baser_xgmii_dec_64 #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .HDR_WIDTH(2), .CNT_WIDTH(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .rx  (bus2.slave)
    );

    typedef struct {
        logic [63:0] rxd;
        logic [7:0]  rxc;
        logic        bad;
        logic        seq;
        logic        fill;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_cnt  = 0;
    int unsigned exp_cnt2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one result per clock, 1 cycle after the stimulus that produced it
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("rxd",   bus1.xgmii_rxd,          mon_e.rxd);
            chk("rxc",   bus1.xgmii_rxc,          mon_e.rxc);
            chk("bad",   bus1.rx_bad_block,       mon_e.bad);
            chk("seq",   bus1.rx_sequence_error,  mon_e.seq);
            chk("fill",  bus1.rx_idle_fill,       mon_e.fill);
            chk("cnt",   bus1.rx_error_count,     mon_e.cnt);
            chk("cnt2",  bus2.rx_error_count,     mon_e.cnt2);
            chk("rxd2",  bus2.xgmii_rxd,          mon_e.rxd);
            chk("excl",  bus1.rx_bad_block & bus1.rx_sequence_error, 64'd0);
        end
    end

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        bus1.encoded_rx_valid = 1'b0;
        exp_cnt  = 0;
        exp_cnt2 = 0;
        e = '{rxd: IDL, rxc: 8'hff, bad: 1'b0, seq: 1'b0, fill: 1'b0, cnt: 16'd0, cnt2: 2'd0};
        sb.push_back(e);
    endtask

    task automatic send(input logic [1:0] h, input logic [63:0] d, input logic v,
                        input logic [63:0] xr, input logic [7:0] xc,
                        input logic b, input logic s, input logic f);
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        bus1.encoded_rx_hdr   = h;
        bus1.encoded_rx_data  = d;
        bus1.encoded_rx_valid = v;
        if (b || s) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        e = '{rxd: xr, rxc: xc, bad: b, seq: s, fill: f,
              cnt: exp_cnt[15:0], cnt2: exp_cnt2[1:0]};
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus1.encoded_rx_valid = 1'b0;
        bus1.encoded_rx_hdr   = 2'b00;
        bus1.encoded_rx_data  = '0;

        do_reset();
        do_reset();
        // idle regeneration after reset
        repeat (3) send(2'b00, 64'h0, 1'b0, IDL, 8'hff, 1'b0, 1'b0, 1'b1);
        // start / data / data / terminate lane 7
        send(2'b01, 64'hd5555555555555_78, 1'b1, 64'hd5555555555555fb, 8'h01, 1'b0, 1'b0, 1'b0);
        send(2'b10, 64'h0123456789abcdef, 1'b1, 64'h0123456789abcdef, 8'h00, 1'b0, 1'b0, 1'b0);
        send(2'b10, 64'hfedcba9876543210, 1'b1, 64'hfedcba9876543210, 8'h00, 1'b0, 1'b0, 1'b0);
        send(2'b01, 64'h11223344556677ff, 1'b1, 64'hfd11223344556677, 8'h80, 1'b0, 1'b0, 1'b0);
        // data while idle
        send(2'b10, 64'h1111111111111111, 1'b1, EB, 8'hff, 1'b0, 1'b1, 1'b0);
        // start then dropped block mid-frame, then normal fill
        send(2'b01, 64'h0000000000000078, 1'b1, 64'h00000000000000fb, 8'h01, 1'b0, 1'b0, 1'b0);
        send(2'b00, 64'h0, 1'b0, EB, 8'hff, 1'b0, 1'b1, 1'b0);
        send(2'b00, 64'h0, 1'b0, IDL, 8'hff, 1'b0, 1'b0, 1'b1);
        // bad type, bad header
        send(2'b01, 64'h0000000000000000, 1'b1, EB, 8'hff, 1'b1, 1'b0, 1'b0);
        send(2'b11, 64'h0123456789abcdef, 1'b1, EB, 8'hff, 1'b1, 1'b0, 1'b0);
        // all-idle control block, and one with an illegal code in lane 0
        send(2'b01, 64'h000000000000001e, 1'b1, IDL, 8'hff, 1'b0, 1'b0, 1'b0);
        send(2'b01, 64'h0000000000007f1e, 1'b1, 64'h07070707070707fe, 8'hff, 1'b1, 1'b0, 1'b0);
        // terminate while idle, then start + terminate lane 0
        send(2'b01, 64'h0000000000000087, 1'b1, EB, 8'hff, 1'b0, 1'b1, 1'b0);
        send(2'b01, 64'h0000000000000078, 1'b1, 64'h00000000000000fb, 8'h01, 1'b0, 1'b0, 1'b0);
        send(2'b01, 64'h0000000000000087, 1'b1, 64'h07070707070707fd, 8'hff, 1'b0, 1'b0, 1'b0);
        // start in lane 4, terminate lane 3
        send(2'b01, 64'haabbcc0000000033, 1'b1, 64'haabbccfb07070707, 8'h1f, 1'b0, 1'b0, 1'b0);
        send(2'b01, 64'h00000000332211b4, 1'b1, 64'h07070707fd332211, 8'hf8, 1'b0, 1'b0, 1'b0);
        // ordered sets, good and bad O code
        send(2'b01, 64'h665544f033221155, 1'b1, 64'h6655445c3322119c, 8'h11, 1'b0, 1'b0, 1'b0);
        send(2'b01, 64'h0000000100000055, 1'b1, EB, 8'hff, 1'b1, 1'b0, 1'b0);
        // O0+S4 start, repeated start (stays in frame), data, then control mid-frame
        send(2'b01, 64'h6655440033221166, 1'b1, 64'h665544fb3322119c, 8'h11, 1'b0, 1'b0, 1'b0);
        send(2'b01, 64'h6655440033221166, 1'b1, EB, 8'hff, 1'b0, 1'b1, 1'b0);
        send(2'b10, 64'hdeadbeefcafef00d, 1'b1, 64'hdeadbeefcafef00d, 8'h00, 1'b0, 1'b0, 1'b0);
        send(2'b01, 64'h000000f00000002d, 1'b1, EB, 8'hff, 1'b0, 1'b1, 1'b0);
        send(2'b01, 64'h000000f00000002d, 1'b1, 64'h0000005c07070707, 8'h1f, 1'b0, 1'b0, 1'b0);
        send(2'b01, 64'h0000000fccbbaa4b, 1'b1, 64'h07070707ccbbaa5c, 8'hf1, 1'b0, 1'b0, 1'b0);
        // reset mid-frame discards the frame
        send(2'b01, 64'h0000000000000078, 1'b1, 64'h00000000000000fb, 8'h01, 1'b0, 1'b0, 1'b0);
        do_reset();
        send(2'b10, 64'h0123456789abcdef, 1'b1, EB, 8'hff, 1'b0, 1'b1, 1'b0);
        // counter saturation on the 2-bit instance
        do_reset();
        repeat (5) send(2'b00, 64'h0, 1'b1, EB, 8'hff, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected results left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
